// File: rtl/pipe_sched_if.sv
// Requester, pipeline and status signals of the two-requester pipeline scheduler.
interface pipe_sched_if #(
  parameter int N = 10
);
  logic         r0_valid, r1_valid;
  logic         r0_ready, r1_ready;
  logic [N-1:0] r0_a, r0_b, r0_c, r0_d;
  logic [N-1:0] r1_a, r1_b, r1_c, r1_d;
  logic         hold;
  logic [N-1:0] p_a, p_b, p_c, p_d;
  logic [N-1:0] p_f;
  logic         res0_valid, res1_valid;
  logic [N-1:0] res_data;
  logic         busy;
  logic [7:0]   issue_cnt0, issue_cnt1;

  // Environment side: requesters plus the shared pipeline.
  modport master (
    output r0_valid, r1_valid, r0_a, r0_b, r0_c, r0_d,
           r1_a, r1_b, r1_c, r1_d, hold, p_f,
    input  r0_ready, r1_ready, p_a, p_b, p_c, p_d,
           res0_valid, res1_valid, res_data, busy, issue_cnt0, issue_cnt1
  );

  modport slave (
    input  r0_valid, r1_valid, r0_a, r0_b, r0_c, r0_d,
           r1_a, r1_b, r1_c, r1_d, hold, p_f,
    output r0_ready, r1_ready, p_a, p_b, p_c, p_d,
           res0_valid, res1_valid, res_data, busy, issue_cnt0, issue_cnt1
  );
endinterface

// File: rtl/pipe_sched.sv
// Round-robin scheduler sharing one fixed-latency pipeline between two requesters;
// a tag shift register tracks which requester owns each in-flight result.
module pipe_sched #(
  parameter int N   = 10,
  parameter int LAT = 3
) (
  input  logic         clk,
  input  logic         rst,
  pipe_sched_if.slave  bus
);

  typedef enum logic {
    REQ0 = 1'b0,
    REQ1 = 1'b1
  } req_e;

  req_e         r_ptr;
  logic [N-1:0] r_p_a, r_p_b, r_p_c, r_p_d;
  logic [LAT:0] r_tag_v;
  logic [LAT:0] r_tag_id;
  logic [7:0]   r_cnt0, r_cnt1;

  req_e         w_gnt;
  logic         w_issue_ok;
  logic         w_r0_ready, w_r1_ready;
  logic         w_xfer0, w_xfer1, w_xfer;

  always_comb begin
    w_gnt = REQ0;
    if (bus.r0_valid && bus.r1_valid) w_gnt = r_ptr;
    else if (bus.r1_valid)            w_gnt = REQ1;
  end

  assign w_issue_ok = !rst && !bus.hold;
  assign w_r0_ready = w_issue_ok && bus.r0_valid && (w_gnt == REQ0);
  assign w_r1_ready = w_issue_ok && bus.r1_valid && (w_gnt == REQ1);
  assign w_xfer0    = w_r0_ready && bus.r0_valid;
  assign w_xfer1    = w_r1_ready && bus.r1_valid;
  assign w_xfer     = w_xfer0 || w_xfer1;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_p_a    <= '0;
      r_p_b    <= '0;
      r_p_c    <= '0;
      r_p_d    <= '0;
      r_tag_v  <= '0;
      r_tag_id <= '0;
      r_ptr    <= REQ0;
      r_cnt0   <= '0;
      r_cnt1   <= '0;
    end else begin
      // Tags never stall: one slot per edge, matching the pipeline's fixed latency.
      r_tag_v  <= {r_tag_v[LAT-1:0], w_xfer};
      r_tag_id <= {r_tag_id[LAT-1:0], w_xfer1};
      if (w_xfer0) begin
        r_p_a  <= bus.r0_a;
        r_p_b  <= bus.r0_b;
        r_p_c  <= bus.r0_c;
        r_p_d  <= bus.r0_d;
        r_ptr  <= REQ1;
        r_cnt0 <= r_cnt0 + 8'd1;
      end else if (w_xfer1) begin
        r_p_a  <= bus.r1_a;
        r_p_b  <= bus.r1_b;
        r_p_c  <= bus.r1_c;
        r_p_d  <= bus.r1_d;
        r_ptr  <= REQ0;
        r_cnt1 <= r_cnt1 + 8'd1;
      end
    end
  end

  assign bus.r0_ready   = w_r0_ready;
  assign bus.r1_ready   = w_r1_ready;
  assign bus.p_a        = r_p_a;
  assign bus.p_b        = r_p_b;
  assign bus.p_c        = r_p_c;
  assign bus.p_d        = r_p_d;
  assign bus.res0_valid = r_tag_v[LAT] && !r_tag_id[LAT];
  assign bus.res1_valid = r_tag_v[LAT] &&  r_tag_id[LAT];
  assign bus.res_data   = bus.p_f;
  assign bus.busy       = |r_tag_v;
  assign bus.issue_cnt0 = r_cnt0;
  assign bus.issue_cnt1 = r_cnt1;

endmodule

// File: doc/pipe_sched.md
PIPE_SCHED -- requirements
Module: pipe_sched

Interface
REQ-001 Parameters SHALL be:
- N, default 10: operand/result width.
- LAT, default 3: rising edges from a p_* change until p_f reflects it.
REQ-002 Ports SHALL be:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset; synchronous, active-high.
- r0_valid / r1_valid  in  1  requester k has operands.
- r0_ready / r1_ready  out  1  scheduler accepts requester k.
- r0_a, r0_b, r0_c, r0_d  in  N  requester 0 operands.
- r1_a, r1_b, r1_c, r1_d  in  N  requester 1 operands.
- hold  in  1  suppresses new issue; in-flight work continues.
- p_a, p_b, p_c, p_d  out  N  registered operands to the shared pipeline.
- p_f  in  N  shared pipeline result.
- res0_valid / res1_valid  out  1  one-cycle result pulse for requester k.
- res_data  out  N  result; equals p_f.
- busy  out  1  any issue in flight.
- issue_cnt0 / issue_cnt1  out  8  accepted-transfer count per requester.

Function
REQ-003 Shared pipeline SHALL compute f = ((a+b)+(c-d))*d mod 2^N; scheduler SHALL pass p_f unchanged (no arithmetic of its own).
REQ-004 Grant SHALL be combinational round-robin over valid requesters; priority pointer names the preferred requester.
REQ-005 rk_ready SHALL be 1 only for the granted requester, and only when rst=0 and hold=0; at most one ready high per cycle.
REQ-006 A transfer SHALL occur on a rising edge where rk_valid & rk_ready.
REQ-007 Only the granted requester is offered ready; its valid SHALL NOT be required to depend on ready.
REQ-008 On transfer edge:
- p_a..p_d SHALL load requester k operands.
- tag stage 1 SHALL load {valid=1, id=k}.
- priority pointer SHALL move to the other requester.
- issue_cntk SHALL increment by 1, wrapping 255->0.
REQ-009 No transfer on an edge:
- p_* SHALL hold their values.
- tag stage 1 SHALL load valid=0.
- pointer SHALL be unchanged.
REQ-010 Tag shift register SHALL have LAT+1 stages {valid, id}, shifting every edge and never stalling.
REQ-011 resk_valid SHALL equal (stage LAT+1 valid AND id==k).
REQ-012 res_data SHALL equal p_f in the cycle after the LAT-th edge following the transfer edge.
REQ-013 Only one result per cycle is possible; res0_valid and res1_valid SHALL never both be 1.
REQ-014 Back-to-back transfers SHALL be supported every cycle (throughput 1/cycle); results emerge in issue order.
REQ-015 Single valid requester SHALL be granted regardless of pointer; both valid -> pointer's requester.
REQ-016 hold=1: both ready 0, no transfer; tags keep shifting so in-flight results still emerge.
REQ-017 busy SHALL be OR of all tag-stage valid bits (registered state only).
REQ-018 Pointer SHALL not advance while hold=1 or on cycles without a transfer.

Reset
REQ-019 While rst=1 on an edge, the following SHALL clear:
- p_a..p_d -> 0.
- all tag valids -> 0.
- pointer -> requester 0.
- issue_cnt0 and issue_cnt1 -> 0.
REQ-020 While rst=1, r0_ready and r1_ready SHALL be 0.
REQ-021 Reset mid-operation SHALL discard in-flight work; no resk_valid pulse for any pre-reset issue.
REQ-022 After reset, res0_valid, res1_valid and busy SHALL be 0 until a new transfer propagates.

Verification (bench models the shared pipeline, N=10, LAT=3)
REQ-023 r0 only, a=2 b=3 c=9 d=5 -> single transfer; res0_valid pulses once 3 edges after the transfer edge with res_data=45; res1_valid stays 0.
REQ-024 Both valid continuously from reset, r0={2,3,9,5}, r1={1,1,7,3} -> grant order 0,1,0,1; results alternate 45 (res0) / 18 (res1), one per cycle.
REQ-025 r0 valid 4 consecutive cycles -> 4 consecutive transfers; 4 consecutive res0_valid pulses; busy high from first transfer through last result, then 0; issue_cnt0=4.
REQ-026 hold=1 after 2 transfers -> readies 0; the 2 results still emerge; busy falls; pointer unchanged; issuing resumes when hold drops.
REQ-027 rst pulsed with 2 in flight -> no res_valid afterward; busy=0; counters 0; next grant with both valid goes to r0.
REQ-028 256 transfers on r1 -> issue_cnt1 wraps to 0; issue_cnt0 stays 0.
